// File: rtl/fq_button_conditioner_pkg.sv
// Shared types and constants for the player push-button conditioning path.
package fq_input_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } btn_state_e;

  localparam int BTN_T1_VU = 0;
  localparam int BTN_T1_VD = 1;
  localparam int BTN_T2_VU = 2;
  localparam int BTN_T2_VD = 3;
  localparam int BTN_T1_HL = 4;
  localparam int BTN_T1_HR = 5;
  localparam int BTN_T2_HL = 6;
  localparam int BTN_T2_HR = 7;

  // One counter width covers the debounce window and both repeat intervals.
  function automatic int cnt_width(input int debounce, input int delay, input int period);
    int m;
    m = debounce;
    if (delay > m) m = delay;
    if (period > m) m = period;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fq_button_conditioner_if.sv
// Button bundle between the pin pads, the conditioner and the game controller.
interface fq_button_conditioner_if #(
  parameter int NUM_BUTTONS = 8
);
  logic [NUM_BUTTONS-1:0] btn_raw_i;
  logic [NUM_BUTTONS-1:0] btn_level_o;
  logic [NUM_BUTTONS-1:0] btn_press_o;
  logic [NUM_BUTTONS-1:0] btn_release_o;

  modport master (
    output btn_raw_i,
    input  btn_level_o,
    input  btn_press_o,
    input  btn_release_o
  );

  modport slave (
    input  btn_raw_i,
    output btn_level_o,
    output btn_press_o,
    output btn_release_o
  );
endinterface

// File: rtl/fq_button_conditioner_debounce_cell.sv
// One button channel: 2-flop synchroniser, debounce FSM, optional auto-repeat.
// Auto-repeat is built only when FQ_AUTO_REPEAT_EN is defined.
module fq_debounce_cell
  import fq_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic             raw_s;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;

  // Sync flops reset to the released pin level so reset never looks like a press.
  // NOTE: every clocked block uses non-blocking assignments so all flops sample
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= pin_i;
      sync2 <= sync1;
    end
  end

  assign raw_s = sync2 ^ ACTIVE_LOW;

`ifdef FQ_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_armed;  // first repeat already fired; use the period from now on
  logic [CNT_W-1:0] rpt_last;

  assign rpt_last = rpt_armed ? RP_LAST : RD_LAST;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RELEASED;
      cnt       <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
`ifdef FQ_AUTO_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
`endif
    end else begin
      press_o   <= 1'b0;
      release_o <= 1'b0;
      case (state)
        ST_RELEASED: begin
          if (raw_s) begin
            state <= ST_PRESS_CHK;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        ST_PRESS_CHK: begin
          if (!raw_s) begin
            state <= ST_RELEASED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state   <= ST_PRESSED;
            level_o <= 1'b1;
            press_o <= 1'b1;
            cnt     <= '0;
`ifdef FQ_AUTO_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!raw_s) begin
            state <= ST_RELEASE_CHK;
            cnt   <= CNT_ONE;
          end
`ifdef FQ_AUTO_REPEAT_EN
          else if (rpt_cnt == rpt_last) begin
            press_o   <= 1'b1;
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + CNT_ONE;
          end
`endif
        end
        ST_RELEASE_CHK: begin
          // The repeat counter is left untouched here, which freezes it.
          if (raw_s) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state     <= ST_RELEASED;
            level_o   <= 1'b0;
            release_o <= 1'b1;
            cnt       <= '0;
`ifdef FQ_AUTO_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fq_button_conditioner.sv
// Conditions the eight raw player buttons into level / press / release signals.
// Optional auto-repeat of press pulses: define FQ_AUTO_REPEAT_EN.
module fq_button_conditioner
  import fq_input_pkg::*;
#(
  parameter int NUM_BUTTONS     = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic                    clk,
  input logic                    rst_n,
  fq_button_conditioner_if.slave btn
);

  logic [NUM_BUTTONS-1:0] level_w;
  logic [NUM_BUTTONS-1:0] press_w;
  logic [NUM_BUTTONS-1:0] release_w;

  // Channels share nothing but the clock and reset.
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_cell
    fq_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin_i    (btn.btn_raw_i[i]),
      .level_o  (level_w[i]),
      .press_o  (press_w[i]),
      .release_o(release_w[i])
    );
  end

  assign btn.btn_level_o   = level_w;
  assign btn.btn_press_o   = press_w;
  assign btn.btn_release_o = release_w;

endmodule
